// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Holds the arbiter state encoding, default parameter values and the helper
// that sizes producer-index signals.
package fifo_arb_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_BURST_LEN = 4;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StGap
    } arb_state_e;

    // Width of an index into n producers; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Searches i_req upward from i_ptr with wrap-around and reports the first set bit.
// Ports:
//   i_req   : request vector
//   i_ptr   : highest-priority index for this search
//   o_found : at least one request bit set
//   o_idx   : index of the winning request (0 when none)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    // One spare bit so ptr + offset never overflows before the explicit wrap.
    logic [IDX_W:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, i_ptr} + (IDX_W + 1)'(k);
            if (w_cand >= (IDX_W + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!o_found && i_req[w_cand[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant lasts at most BURST_LEN accepted beats, ends early when the owner drops
// its request, and is always followed by a one-cycle gap before re-arbitration.
// Ports:
//   i_clk, i_reset            : clock, asynchronous active-high reset
//   i_req, i_req_valid        : per-producer request level and beat valid
//   i_req_data                : packed producer data, producer i at [i*WIDTH +: WIDTH]
//   o_gnt, o_owner, o_busy    : registered one-hot grant, owner index, in-transfer flag
//   o_beat_ack                : one-hot, owner's beat written this cycle
//   i_fifo_full               : FIFO full flag
//   o_fifo_wr, o_fifo_data    : FIFO write enable and data
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned  WIDTH     = DEF_WIDTH,
    parameter int unsigned  BURST_LEN = DEF_BURST_LEN,
    localparam int unsigned IDX_W     = idx_width(NUM_REQ),
    localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [NUM_REQ-1:0]         o_beat_ack,
    input  logic                       i_fifo_full,
    output logic                       o_fifo_wr,
    output logic [WIDTH-1:0]           o_fifo_data,
    output logic [IDX_W-1:0]           o_owner,
    output logic                       o_busy
);

    arb_state_e         r_state;
    arb_state_e         w_state_next;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic               w_pick_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_own_req;
    logic               w_accept;
    logic               w_last_beat;
    logic [IDX_W-1:0]   w_owner_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_own_req   = i_req[r_owner];
        // A beat is never accepted once the owner has released its request.
        w_accept    = (r_state == StXfer) && w_own_req && i_req_valid[r_owner] && !i_fifo_full;
        w_last_beat = w_accept && (r_beat_cnt == CNT_W'(BURST_LEN - 1));
        // Explicit wrap: NUM_REQ need not be a power of two.
        w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_pick_found) w_state_next = StXfer;
            StXfer:  if (!w_own_req || w_last_beat) w_state_next = StGap;
            StGap:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase

        o_fifo_wr   = w_accept;
        o_fifo_data = i_req_data[r_owner*WIDTH +: WIDTH];
        o_beat_ack  = '0;
        if (w_accept) o_beat_ack[r_owner] = 1'b1;
        o_busy      = (r_state == StXfer);
        o_gnt       = r_gnt;
        o_owner     = r_owner;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_found) begin
                        r_gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_owner    <= w_pick_idx;
                        r_beat_cnt <= '0;
                    end
                end
                StXfer: begin
                    if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
                    if (w_state_next == StGap) r_gnt <= '0;
                end
                StGap: begin
                    // The producer that just finished becomes lowest priority.
                    r_rr_ptr <= w_owner_inc;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, BURST_LEN=4).
// Each producer drives {index, beat count} so written data shows order and source.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        i_reset;
    logic [3:0]  i_req;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_gnt;
    logic [3:0]  o_beat_ack;
    logic        i_fifo_full;
    logic        o_fifo_wr;
    logic [7:0]  o_fifo_data;
    logic [1:0]  o_owner;
    logic        o_busy;

    int unsigned n_pass;
    int unsigned n_total;

    logic [3:0]  p_cnt [4];

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .BURST_LEN (4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_gnt       (o_gnt),
        .o_beat_ack  (o_beat_ack),
        .i_fifo_full (i_fifo_full),
        .o_fifo_wr   (o_fifo_wr),
        .o_fifo_data (o_fifo_data),
        .o_owner     (o_owner),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer model: advance its beat counter on each acknowledged beat.
    always @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) p_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) if (o_beat_ack[i]) p_cnt[i] <= p_cnt[i] + 4'd1;
        end
    end

    always_comb begin
        i_req_data = '0;
        for (int i = 0; i < 4; i++) i_req_data[i*8 +: 8] = {4'(i), p_cnt[i]};
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] vld;
        logic       full;
        logic [3:0] gnt;
        logic       wr;
        logic       busy;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] vld,
                                input logic full, input logic [3:0] gnt, input logic wr,
                                input logic busy, input logic [7:0] data);
        vec_t v;
        v.rst = rst; v.req = req; v.vld = vld; v.full = full;
        v.gnt = gnt; v.wr = wr; v.busy = busy; v.data = data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1; i_req = '0; i_req_valid = '0; i_fifo_full = 1'b0;
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        i_reset = 1'b1; i_req = '0; i_req_valid = '0; i_fifo_full = 1'b0;

        // Single producer, 10 words: bursts of 4 with a 2-cycle gap, then early drop.
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 8'h00));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 4'h1, 4'h1, 0, 4'h1, 1, 1, 8'(k)));
        repeat (2) tbl.push_back(mk(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 8'h00));
        for (int k = 4; k < 8; k++) tbl.push_back(mk(0, 4'h1, 4'h1, 0, 4'h1, 1, 1, 8'(k)));
        repeat (2) tbl.push_back(mk(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 8'h00));
        for (int k = 8; k < 10; k++) tbl.push_back(mk(0, 4'h1, 4'h1, 0, 4'h1, 1, 1, 8'(k)));
        tbl.push_back(mk(0, 4'h0, 4'h1, 0, 4'h1, 0, 1, 8'h00));
        repeat (2) tbl.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 8'h00));

        // Backpressure: producer 2 stalled for 5 cycles after beat 2.
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h4, 4'h4, 0, 4'h0, 0, 0, 8'h00));
        for (int k = 0; k < 2; k++) tbl.push_back(mk(0, 4'h4, 4'h4, 0, 4'h4, 1, 1, 8'h20 + 8'(k)));
        repeat (5) tbl.push_back(mk(0, 4'h4, 4'h4, 1, 4'h4, 0, 1, 8'h00));
        for (int k = 2; k < 4; k++) tbl.push_back(mk(0, 4'h4, 4'h4, 0, 4'h4, 1, 1, 8'h20 + 8'(k)));
        tbl.push_back(mk(0, 4'h4, 4'h4, 0, 4'h0, 0, 0, 8'h00));

        // Early release by producer 1: producer 3 is served before producer 0.
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h2, 4'h2, 0, 4'h0, 0, 0, 8'h00));
        for (int k = 0; k < 2; k++) tbl.push_back(mk(0, 4'h2, 4'h2, 0, 4'h2, 1, 1, 8'h10 + 8'(k)));
        tbl.push_back(mk(0, 4'h9, 4'hb, 0, 4'h2, 0, 1, 8'h00));
        repeat (2) tbl.push_back(mk(0, 4'h9, 4'h9, 0, 4'h0, 0, 0, 8'h00));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 4'h9, 4'h9, 0, 4'h8, 1, 1, 8'h30 + 8'(k)));
        repeat (2) tbl.push_back(mk(0, 4'h9, 4'h9, 0, 4'h0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h9, 4'h9, 0, 4'h1, 1, 1, 8'h00));

        // Bubbles: valid toggles, grant persists until 4 beats are accepted.
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 8'h00));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(0, 4'h1, 4'h1, 0, 4'h1, 1, 1, 8'(k)));
            if (k < 3) tbl.push_back(mk(0, 4'h1, 4'h0, 0, 4'h1, 0, 1, 8'h00));
        end
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 4'h0, 0, 0, 8'h00));

        tick();
        foreach (tbl[n]) begin
            i_reset     = tbl[n].rst;
            i_req       = tbl[n].req;
            i_req_valid = tbl[n].vld;
            i_fifo_full = tbl[n].full;
            @(negedge clk);
            chk($sformatf("row%0d gnt", n), 32'(o_gnt), 32'(tbl[n].gnt));
            chk($sformatf("row%0d fifo_wr", n), 32'(o_fifo_wr), 32'(tbl[n].wr));
            chk($sformatf("row%0d beat_ack", n), 32'(o_beat_ack),
                32'(tbl[n].wr ? tbl[n].gnt : 4'h0));
            chk($sformatf("row%0d busy", n), 32'(o_busy), 32'(tbl[n].busy));
            if (tbl[n].wr) chk($sformatf("row%0d data", n), 32'(o_fifo_data), 32'(tbl[n].data));
            tick();
        end

        // Round-robin with all four requesting: owners 0,1,2,3,0, four beats each.
        pulse_reset();
        i_req = 4'hf; i_req_valid = 4'hf;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) begin
                automatic bit seen = 1'b0;
                automatic int own = b % 4;
                for (int w = 0; w < 8; w++) begin
                    @(negedge clk);
                    if (o_fifo_wr) begin
                        seen = 1'b1;
                        break;
                    end
                    tick();
                end
                chk($sformatf("rr b%0d k%0d write seen", b, k), 32'(seen), 32'd1);
                if (seen) begin
                    chk($sformatf("rr b%0d k%0d owner", b, k), 32'(o_owner), 32'(own));
                    chk($sformatf("rr b%0d k%0d gnt", b, k), 32'(o_gnt), 32'(4'h1 << own));
                    chk($sformatf("rr b%0d k%0d data", b, k), 32'(o_fifo_data),
                        32'({4'(own), 4'((b == 4 ? 4 : 0) + k)}));
                end
                tick();
            end
        end

        // Async reset mid-burst; arbitration must restart from pointer 0.
        pulse_reset();
        i_req = 4'h2; i_req_valid = 4'h2;
        repeat (5) tick();
        i_req = 4'h0; i_req_valid = 4'h0;
        repeat (2) tick();
        i_req = 4'h4; i_req_valid = 4'h4;
        repeat (2) tick();
        chk("areset pre gnt", 32'(o_gnt), 32'h4);
        chk("areset pre fifo_wr", 32'(o_fifo_wr), 32'd1);
        #2 i_reset = 1'b1;
        #1;
        chk("areset gnt", 32'(o_gnt), 32'h0);
        chk("areset fifo_wr", 32'(o_fifo_wr), 32'd0);
        chk("areset busy", 32'(o_busy), 32'd0);
        chk("areset beat_ack", 32'(o_beat_ack), 32'h0);
        tick();
        i_reset = 1'b0; i_req = 4'hf; i_req_valid = 4'hf;
        @(negedge clk);
        chk("post reset idle gnt", 32'(o_gnt), 32'h0);
        tick();
        @(negedge clk);
        chk("post reset gnt", 32'(o_gnt), 32'h1);
        chk("post reset owner", 32'(o_owner), 32'd0);
        chk("post reset data", 32'(o_fifo_data), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the team's 8x8 FIFO between NUM_REQ producers on one clock domain. Uses round-robin grant with bounded bursts, so one producer cannot monopolise the FIFO. Forwards the granted producer's data to the FIFO write port and throttles it on the FIFO full flag. Sits between the producer blocks and the FIFO's wr/data_in/full pins.

Parameters:
NUM_REQ, 4, number of requesting producers (2..8)
WIDTH, 8, data word width; must match the FIFO width
BURST_LEN, 4, maximum beats per grant before forced re-arbitration (1..16)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-producer request; level, held while the producer has data
req_valid  input  NUM_REQ  per-producer beat valid; meaningful only for the granted producer
req_data  input  NUM_REQ*WIDTH  packed producer data; producer i occupies bits [i*WIDTH +: WIDTH]
gnt  output  NUM_REQ  one-hot grant (registered); all-zero when no producer owns the port
beat_ack  output  NUM_REQ  one-hot; high in a cycle where the owner's beat is written
fifo_full  input  1  full flag from the FIFO
fifo_wr  output  1  FIFO write enable
fifo_data  output  WIDTH  FIFO write data
owner  output  $clog2(NUM_REQ)  index of the current grant holder; valid when busy=1
busy  output  1  high while in XFER

Behaviour:
- Reset values (async, on reset=1): state=IDLE, gnt=0, owner=0, busy=0, rr_ptr=0, beat_cnt=0. fifo_wr=0 and beat_ack=0 because they are combinational from state=IDLE.
- States: IDLE, XFER, GAP.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... NUM_REQ-1, 0, ...).
  - On the next edge: register gnt (one-hot) and owner, clear beat_cnt, go to XFER.
  - Grant latency is 1 cycle from req to gnt.
  - With no req, stay in IDLE.
- XFER:
  - accept = req_valid[owner] & ~fifo_full.
  - fifo_wr = accept; fifo_data = req_data slice of owner; beat_ack[owner] = accept. All are combinational with zero latency.
  - Each accept increments beat_cnt.
  - fifo_full=1 stalls the beat: no write, no count, grant held. There is no timeout.
  - req_valid=0 with req[owner]=1 is a bubble: grant is held.
- Burst end (leave XFER for GAP at the next edge):
  - (a) accept occurs and beat_cnt == BURST_LEN-1, or
  - (b) req[owner]=0; early release, and any simultaneous beat is not accepted.
- GAP:
  - gnt=0 and busy=0 for exactly one cycle.
  - rr_ptr = owner+1, wrapping to 0 at NUM_REQ.
  - Go to IDLE.
  - The gap guarantees the FIFO full flag has settled before the next owner writes.
- Simultaneous requests: the lowest index at or above rr_ptr wins. A producer that just finished is lowest priority on the next round.
- Single requester: it is re-granted after a 2-cycle gap (GAP, IDLE). Maximum sustained rate is BURST_LEN beats per BURST_LEN+2 cycles.
- Widths:
  - beat_cnt is $clog2(BURST_LEN+1) bits.
  - rr_ptr and owner wrap modulo NUM_REQ explicitly; they must not rely on power-of-two overflow.
- Reset mid-burst: immediate return to IDLE, with gnt and fifo_wr low in the same cycle. FIFO contents are untouched; the FIFO has its own reset.
- Invariants: gnt is always one-hot or zero. fifo_wr=1 implies fifo_full=0 and busy=1.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, XFER, GAP)
  - default constants for NUM_REQ, WIDTH, BURST_LEN
  - the function computing the index width
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, index.
  - Parameterised by NUM_REQ, and reusable on the read side.

Test Plan:
- Single producer: req=0001, req_valid=1, fifo_full=0, 10 words streamed -> gnt=0001 one cycle after req. Writes occur in bursts of 4 separated by 2 idle cycles, for 10 fifo_wr pulses in total, with data in order.
- Round-robin: req=1111 held constant, all valid -> grant order is 0,1,2,3,0 with 4 beats each. Every fifo_data word matches its owner's slice.
- Backpressure: producer 2 owns the port, fifo_full=1 for 5 cycles mid-burst after beat 2 -> no fifo_wr and no beat_ack during the stall, gnt held. The remaining 2 beats complete after full drops.
- Early release: producer 1 drops req after 2 beats -> GAP next cycle, rr_ptr=2. A waiting producer 3 is granted ahead of producer 0.
- Async reset: reset asserted in XFER after beat 1, between clock edges -> gnt=0, fifo_wr=0, busy=0 immediately. After release, arbitration restarts from rr_ptr=0.
- Bubbles: owner toggles req_valid 1,0,1,0 -> fifo_wr follows the valid pattern and the grant persists until 4 beats are accepted.
